// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// Imported by the fetch stage, its redirect-target mux and the bench.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: single-outstanding request strobe
// and a response valid/data pair.
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage_target.sv
// Redirect-target mux for the instruction held in IF/ID.
// Priority is jr > j > branch; reused by later BTB logic.
module fetch_target
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc_id,
  input  logic [31:0] instr_id,
  input  logic [31:0] jr_pc,
  input  logic        jump_reg,
  input  logic        jump_target,
  input  logic        jump_branch,
  output logic [31:0] target
);

  logic [31:0] seq_pc;

  assign seq_pc = pc_id + 32'd4;

  // flags may overlap, so this is a priority chain
  always_comb begin
    target = seq_pc;
    if (jump_reg) begin
      target = jr_pc;
    end else if (jump_target) begin
      target = {seq_pc[31:28], instr_id[25:0], 2'b00};
    end else if (jump_branch) begin
      target = seq_pc + branch_offset(instr_id[15:0]);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS fetch stage: PC, single-outstanding imem reads, IF/ID
// register plus one skid entry, delay-slot-aware redirects.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          jump_branch,
  input  logic          jump_target,
  input  logic          jump_reg,
  input  logic [31:0]   jr_pc,
  fetch_stage_if.master imem,
  output logic [31:0]   pc_id,
  output logic [31:0]   instr_id,
  output logic          valid_id
);

  fetch_state_t st, st_nx;
  if_id_t       ifid, ifid_nx;
  if_id_t       hold, hold_nx;
  if_id_t       rsp_ent;
  logic [31:0]  fetch_pc, fetch_pc_nx;
  logic [31:0]  req_pc, req_pc_nx;
  logic [31:0]  target, addr;
  logic [1:0]   used;
  logic         fire, rsp, redirect, issue;

  fetch_target u_target (
    .pc_id       (ifid.pc),
    .instr_id    (ifid.instr),
    .jr_pc       (jr_pc),
    .jump_reg    (jump_reg),
    .jump_target (jump_target),
    .jump_branch (jump_branch),
    .target      (target)
  );

  assign fire     = ifid.valid && !stall;
  assign rsp      = imem.imem_rvalid && (st == S_WAIT);
  assign redirect = fire && (jump_reg || jump_target || jump_branch);
  assign rsp_ent  = '{pc: req_pc, instr: imem.imem_rdata, valid: 1'b1};

  // IF/ID + skid occupancy after this edge; new request must fit too
  assign used  = 2'(ifid.valid) + 2'(hold.valid) + 2'(rsp) - 2'(fire);
  assign issue = rst_n && (st == S_IDLE || rsp) && (used < 2'd2);
  assign addr  = redirect ? target : fetch_pc;

  assign imem.imem_req  = issue;
  assign imem.imem_addr = addr;

  assign pc_id    = ifid.pc;
  assign instr_id = ifid.instr;
  assign valid_id = ifid.valid;

  always_comb begin
    st_nx       = st;
    fetch_pc_nx = fetch_pc;
    req_pc_nx   = req_pc;
    if (issue) begin
      st_nx       = S_WAIT;
      fetch_pc_nx = addr + 32'd4;
      req_pc_nx   = addr;
    end else begin
      if (rsp)      st_nx       = S_IDLE;
      if (redirect) fetch_pc_nx = target;
    end
  end

  always_comb begin
    ifid_nx = ifid;
    hold_nx = hold;
    if (fire || !ifid.valid) begin
      if (hold.valid) begin
        ifid_nx = hold;
        hold_nx = rsp ? rsp_ent : '0;
      end else if (rsp) begin
        ifid_nx = rsp_ent;
      end else if (fire) begin
        ifid_nx.valid = 1'b0;
        ifid_nx.instr = NOP_INSTR;
      end
    end else if (rsp) begin
      hold_nx = rsp_ent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      ifid     <= '0;
      hold     <= '0;
    end else begin
      st       <= st_nx;
      fetch_pc <= fetch_pc_nx;
      req_pc   <= req_pc_nx;
      ifid     <= ifid_nx;
      hold     <= hold_nx;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency imem model and a
// program-order model of the instruction stream seen by decode.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] br_pc;
    logic [31:0] word;
    logic        r, t, b;
    logic [31:0] jr_val;
    logic [31:0] tgt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall = 1'b0;
  logic        jump_branch = 1'b0, jump_target = 1'b0, jump_reg = 1'b0;
  logic [31:0] jr_pc = '0;
  logic [31:0] pc_id, instr_id;
  logic        valid_id;

  fetch_stage_if bus();

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .jump_branch (jump_branch),
    .jump_target (jump_target),
    .jump_reg    (jump_reg),
    .jr_pc       (jr_pc),
    .imem        (bus),
    .pc_id       (pc_id),
    .instr_id    (instr_id),
    .valid_id    (valid_id)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  vec_t vecs[5];

  // stimulus knobs
  int lat_min = 1, lat_max = 1, stall_pct = 0, stray_pct = 0;
  bit rand_flags = 0, force_stall = 0, force_stray = 0, rel = 0;
  bit dir_en = 0;
  logic [31:0] dir_pc, dir_word, dir_jr, dir_tgt;
  logic dir_r, dir_t, dir_b;

  // memory model
  bit pending = 0;
  logic [31:0] pend_addr = '0;
  int cnt = 0;

  // program-order model
  logic [31:0] exp_pc, saved_tgt;
  bit armed = 0, br_seen = 0;
  int since_br = 0, fires = 0;

  // samples
  logic s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (dir_en && a == dir_pc) return dir_word;
    return a ^ 32'h5A00_0000;
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc,
      input logic [31:0] ins, input logic r, input logic t,
      input logic [31:0] jrv);
    logic [31:0] nxt;
    nxt = pc + 32'd4;
    if (r) return jrv;
    if (t) return {nxt[31:28], ins[25:0], 2'b00};
    return nxt + {{16{ins[15]}}, ins[15:0]} * 32'd4;
  endfunction

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    {jump_reg, jump_target, jump_branch} = 3'b000;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    pending = 0; armed = 0; br_seen = 0; since_br = 0; fires = 0;
    exp_pc = RESET_VECTOR;
    #1;
    chk(bus.imem_req == 1'b0, "rst_req", 32'(bus.imem_req), 32'h0);
    chk(bus.imem_addr == RESET_VECTOR, "rst_addr", bus.imem_addr, RESET_VECTOR);
    chk(pc_id == 32'h0, "rst_pc_id", pc_id, 32'h0);
    chk(instr_id == 32'h0, "rst_instr_id", instr_id, 32'h0);
    chk(valid_id == 1'b0, "rst_valid_id", 32'(valid_id), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rel = 1;
  endtask

  task automatic cycle();
    bit was_pend, resp, fire;
    logic [31:0] nxt;
    @(posedge clk);
    #1;
    if (rel) begin
      rst_n = 1'b1;
      rel = 0;
    end
    was_pend = pending;
    resp = 0;
    if (pending) begin
      if (cnt == 0) begin
        resp = 1;
        pending = 0;
      end else begin
        cnt--;
      end
    end
    bus.imem_rvalid = resp;
    bus.imem_rdata = resp ? mem_word(pend_addr) : 32'h0BAD_0BAD;
    if (!was_pend && (force_stray || $urandom_range(99) < stray_pct)) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
    end
    force_stray = 0;
    stall = force_stall || ($urandom_range(99) < stall_pct);
    {jump_reg, jump_target, jump_branch} = 3'b000;
    if (valid_id && !armed) begin
      if (dir_en && pc_id == dir_pc) begin
        {jump_reg, jump_target, jump_branch} = {dir_r, dir_t, dir_b};
        jr_pc = dir_jr;
      end else if (rand_flags && $urandom_range(99) < 15) begin
        {jump_reg, jump_target, jump_branch} = 3'($urandom_range(7, 1));
        jr_pc = $urandom() & 32'hFFFF_FFFC;
      end
    end
    @(negedge clk);
    s_req = bus.imem_req;
    s_addr = bus.imem_addr;
    s_valid = valid_id;
    s_pc = pc_id;
    s_instr = instr_id;
    if (!s_valid) chk(s_instr == 32'h0, "nop_when_empty", s_instr, 32'h0);
    if (s_req) begin
      chk(!pending, "single_outstanding", s_addr, pend_addr);
      chk(s_addr[1:0] == 2'b00, "addr_align", s_addr, s_addr & 32'hFFFF_FFFC);
    end
    fire = s_valid && !stall;
    if (fire) begin
      fires++;
      chk(s_pc == exp_pc, "fire_pc", s_pc, exp_pc);
      chk(s_instr == mem_word(exp_pc), "fire_instr", s_instr, mem_word(exp_pc));
      if (armed) begin
        nxt = saved_tgt;
        armed = 0;
      end else begin
        nxt = exp_pc + 32'd4;
      end
      if (jump_reg || jump_target || jump_branch) begin
        saved_tgt = dir_en ? dir_tgt :
          ref_target(exp_pc, mem_word(exp_pc), jump_reg, jump_target, jr_pc);
        armed = 1;
        if (dir_en) begin
          br_seen = 1;
          since_br = 0;
          if (lat_max == 1)
            chk(s_req && s_addr == dir_tgt, "redir_addr", s_addr, dir_tgt);
        end
      end else if (br_seen) begin
        since_br++;
      end
      exp_pc = nxt;
    end
    if (s_req) begin
      pending = 1;
      pend_addr = s_addr;
      cnt = int'($urandom_range(lat_max, lat_min)) - 1;
    end
  endtask

  initial begin
    vecs[0] = '{"beq",  32'h10, 32'h1000_0003, 1'b0, 1'b0, 1'b1, 32'h0,   32'h20};
    vecs[1] = '{"jr",   32'h40, 32'h0800_0099, 1'b1, 1'b1, 1'b0, 32'h100, 32'h100};
    vecs[2] = '{"j",    32'h80, 32'h0800_0123, 1'b0, 1'b1, 1'b1, 32'h0,   32'h48C};
    vecs[3] = '{"bwd",  32'h30, 32'h1000_FFF8, 1'b0, 1'b0, 1'b1, 32'h0,   32'h14};
    vecs[4] = '{"wrap", 32'h00, 32'h1000_FFFE, 1'b0, 1'b0, 1'b1, 32'h0,   32'hFFFF_FFFC};

    rst_n = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    #2;

    // straight-line code, L=1
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk(s_req == 1'b1 && s_addr == 32'(4 * k), "line_addr", s_addr, 32'(4 * k));
      chk(s_valid == (k >= 2), "line_valid", 32'(s_valid), 32'(k >= 2));
      if (k >= 2) chk(s_pc == 32'(4 * (k - 2)), "line_pc", s_pc, 32'(4 * (k - 2)));
    end

    // decode stall for three cycles fills the skid
    do_reset();
    repeat (4) cycle();
    force_stall = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk(s_req == 1'b0, "stall_req", 32'(s_req), 32'h0);
    end
    force_stall = 0;
    cycle();
    chk(s_req == 1'b1 && s_addr == 32'h10, "stall_resume", s_addr, 32'h10);
    repeat (6) cycle();
    chk(fires == 9, "stall_fires", 32'(fires), 32'd9);

    // redirect table, L=1
    foreach (vecs[i]) begin
      do_reset();
      dir_en = 1;
      dir_pc = vecs[i].br_pc;
      dir_word = vecs[i].word;
      dir_r = vecs[i].r;
      dir_t = vecs[i].t;
      dir_b = vecs[i].b;
      dir_jr = vecs[i].jr_val;
      dir_tgt = vecs[i].tgt;
      for (int c = 0; c < 80 && !(br_seen && since_br >= 2); c++) cycle();
      chk(br_seen && since_br >= 2, {"redir_done_", vecs[i].name},
          32'(since_br), 32'd2);
      dir_en = 0;
    end

    // reset while a long-latency read is outstanding
    lat_min = 5;
    lat_max = 5;
    do_reset();
    repeat (3) cycle();
    lat_min = 1;
    lat_max = 1;
    do_reset();
    force_stray = 1;
    cycle();
    chk(s_req && s_addr == RESET_VECTOR, "restart_addr", s_addr, RESET_VECTOR);
    repeat (4) cycle();
    chk(fires >= 2, "restart_progress", 32'(fires), 32'd2);

    // random latency, stalls, stray responses and redirects
    do_reset();
    lat_min = 1;
    lat_max = 4;
    stall_pct = 30;
    stray_pct = 20;
    rand_flags = 1;
    repeat (3000) cycle();
    chk(fires > 300, "rand_progress", 32'(fires), 32'd300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
